// File: rtl/bus_read_steering.sv
// Read-data steering: locks one of SOURCES internal sources (or the external bus) for a
// whole read cycle, applies per-source wait states and a ready-timeout watchdog.
module bus_read_steering #(
  parameter int unsigned SOURCES        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned WAIT_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             memory_read_n,
  input  logic                             io_read_n,
  input  logic [SOURCES-1:0]               source_select_n,
  input  logic [SOURCES*DATA_WIDTH-1:0]    source_data,
  input  logic [SOURCES-1:0]               source_ready,
  input  logic [SOURCES*WAIT_WIDTH-1:0]    wait_states,
  input  logic                             external_direction,
  input  logic [DATA_WIDTH-1:0]            data_bus_ext,
  output logic [DATA_WIDTH-1:0]            data_bus_out,
  output logic                             data_bus_direction,
  output logic [SOURCES-1:0]               source_grant,
  output logic                             access_ready,
  output logic                             bus_timeout
);

  localparam int unsigned IdxW = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StDrive} state_e;

  state_e                state_q;
  logic [IdxW-1:0]       win_idx_q;
  logic                  win_int_q;
  logic                  win_ext_q;
  logic                  forced_q;
  logic [WAIT_WIDTH-1:0] wait_cnt_q;
  logic [TmoW-1:0]       tmo_cnt_q;

  logic                  read_active;
  logic                  arb_found;
  logic [IdxW-1:0]       arb_idx;
  logic [WAIT_WIDTH-1:0] arb_wait;
  logic                  arb_ready;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  win_ready;
  logic [WAIT_WIDTH-1:0] wait_dec;
  logic [TmoW-1:0]       tmo_inc;
  logic [DATA_WIDTH-1:0] drive_data;

  assign read_active = ~memory_read_n | ~io_read_n;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < int'(SOURCES); i++) begin
      if (!source_select_n[i] && !arb_found) begin
        arb_found = 1'b1;
        arb_idx   = IdxW'(i);
      end
    end

    arb_wait  = '0;
    arb_ready = 1'b0;
    win_data  = '0;
    win_ready = 1'b0;
    for (int i = 0; i < int'(SOURCES); i++) begin
      if (arb_idx == IdxW'(i)) begin
        arb_wait  = wait_states[i*WAIT_WIDTH +: WAIT_WIDTH];
        arb_ready = source_ready[i];
      end
      if (win_idx_q == IdxW'(i)) begin
        win_data  = source_data[i*DATA_WIDTH +: DATA_WIDTH];
        win_ready = source_ready[i];
      end
    end

    wait_dec = (wait_cnt_q == '0) ? '0 : wait_cnt_q - 1'b1;
    // Saturate so the watchdog counter never wraps, even with the timeout disabled.
    tmo_inc  = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

    if (forced_q)       drive_data = '1;
    else if (win_int_q) drive_data = win_data;
    else if (win_ext_q) drive_data = data_bus_ext;
    else                drive_data = '0;
  end

  // The detection cycle stalls combinationally; everything else is registered.
  always_comb begin
    access_ready = ~((state_q == StWait) | ((state_q == StIdle) & read_active & reset_n));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= StIdle;
      win_idx_q          <= '0;
      win_int_q          <= 1'b0;
      win_ext_q          <= 1'b0;
      forced_q           <= 1'b0;
      wait_cnt_q         <= '0;
      tmo_cnt_q          <= '0;
      data_bus_out       <= '0;
      data_bus_direction <= 1'b0;
      source_grant       <= '0;
      bus_timeout        <= 1'b0;
    end else begin
      bus_timeout <= 1'b0;
      if (!read_active) begin
        state_q            <= StIdle;
        forced_q           <= 1'b0;
        data_bus_out       <= '0;
        data_bus_direction <= 1'b0;
        source_grant       <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            tmo_cnt_q <= '0;
            forced_q  <= 1'b0;
            if (arb_found) begin
              win_idx_q          <= arb_idx;
              win_int_q          <= 1'b1;
              win_ext_q          <= 1'b0;
              wait_cnt_q         <= arb_wait;
              source_grant       <= SOURCES'(1) << arb_idx;
              data_bus_direction <= 1'b0;
              state_q            <= ((arb_wait != '0) || !arb_ready) ? StWait : StDrive;
            end else begin
              win_idx_q          <= '0;
              win_int_q          <= 1'b0;
              win_ext_q          <= external_direction;
              wait_cnt_q         <= '0;
              source_grant       <= '0;
              data_bus_direction <= external_direction;
              state_q            <= StDrive;
            end
          end
          StWait: begin
            wait_cnt_q <= wait_dec;
            tmo_cnt_q  <= tmo_inc;
            // Normal completion takes precedence over a coincident timeout.
            if ((wait_dec == '0) && win_ready) begin
              state_q <= StDrive;
            end else if ((TIMEOUT_CYCLES != 0) && (tmo_inc == TmoLimit)) begin
              state_q      <= StDrive;
              forced_q     <= 1'b1;
              bus_timeout  <= 1'b1;
              data_bus_out <= '1;
            end
          end
          StDrive: begin
            data_bus_out <= drive_data;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_read_steering.sv
// Randomised scoreboard bench for bus_read_steering: a driver pushes the expected outcome
// of each read cycle, a negedge monitor pops and compares when the DUT completes.
module tb_bus_read_steering;

  localparam int SRC = 4;
  localparam int DW  = 8;
  localparam int WW  = 4;
  localparam int TMO = 8;
  localparam int NEVER = 1000;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              memory_read_n = 1'b1;
  logic              io_read_n = 1'b1;
  logic [SRC-1:0]    source_select_n = '1;
  logic [SRC*DW-1:0] source_data = '0;
  logic [SRC-1:0]    source_ready = '1;
  logic [SRC*WW-1:0] wait_states = '0;
  logic              external_direction = 1'b0;
  logic [DW-1:0]     data_bus_ext = '0;
  logic [DW-1:0]     data_bus_out;
  logic              data_bus_direction;
  logic [SRC-1:0]    source_grant;
  logic              access_ready;
  logic              bus_timeout;

  always #5 clock = ~clock;

  bus_read_steering #(
    .SOURCES(SRC), .DATA_WIDTH(DW), .WAIT_WIDTH(WW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .memory_read_n(memory_read_n), .io_read_n(io_read_n),
    .source_select_n(source_select_n), .source_data(source_data), .source_ready(source_ready),
    .wait_states(wait_states), .external_direction(external_direction),
    .data_bus_ext(data_bus_ext), .data_bus_out(data_bus_out),
    .data_bus_direction(data_bus_direction), .source_grant(source_grant),
    .access_ready(access_ready), .bus_timeout(bus_timeout)
  );

  typedef struct {
    bit             abort;
    logic [SRC-1:0] grant;
    logic           dir;
    logic [DW-1:0]  data;
    logic           tmo;
    int             stall;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outcome of one read cycle from the selection rules and the cycle at
  // which the winner's ready rises (ready_at), expressed as plain arithmetic.
  task automatic run_txn(input logic [SRC-1:0] sel, input logic ext, input int ready_at,
                         input int abort_at, input int hold, input int gap, input bit use_io);
    exp_t e;
    int   win;
    int   w;
    int   k;
    int   waits;
    int   len;
    win = -1;
    for (int i = SRC - 1; i >= 0; i--) if (!sel[i]) win = i;
    e.tmo = 1'b0;
    e.dir = 1'b0;
    e.grant = '0;
    waits = 0;
    if (win >= 0) begin
      w = int'(wait_states[win*WW +: WW]);
      e.grant = SRC'(1) << win;
      e.data = source_data[win*DW +: DW];
      if (w == 0 && ready_at == 0) begin
        waits = 0;
      end else begin
        k = (w > ready_at) ? w : ready_at;
        if (k > TMO) begin
          waits = TMO;
          e.tmo = 1'b1;
          e.data = '1;
        end else begin
          waits = k;
        end
      end
    end else begin
      e.dir = ext;
      e.data = ext ? data_bus_ext : '0;
    end
    if (abort_at > 0 && abort_at < 1 + waits) begin
      e.abort = 1'b1;
      e.stall = abort_at;
      len = abort_at;
    end else begin
      e.abort = 1'b0;
      e.stall = 1 + waits;
      len = 1 + waits + hold;
    end
    sb_q.push_back(e);
    for (int c = 0; c < len; c++) begin
      @(posedge clock);
      #1;
      memory_read_n = use_io;
      io_read_n = ~use_io;
      if (c == 0) begin
        source_select_n = sel;
        external_direction = ext;
      end else begin
        source_select_n = SRC'($urandom);
        external_direction = 1'($urandom);
      end
      source_ready = SRC'($urandom);
      if (win >= 0) source_ready[win] = (c >= ready_at);
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clock);
      #1;
      memory_read_n = 1'b1;
      io_read_n = 1'b1;
      source_select_n = SRC'($urandom);
      source_ready = SRC'($urandom);
    end
  endtask

  // Monitor
  bit             in_txn, done, data_pend, post_rel;
  int             stall_cnt;
  logic [DW-1:0]  pend_data;
  logic [SRC-1:0] cur_grant;

  always @(negedge clock) begin
    exp_t e;
    bit   ra;
    if (!reset_n || !mon_en) begin
      in_txn = 0; done = 0; data_pend = 0; post_rel = 0;
    end else begin
      ra = !memory_read_n || !io_read_n;
      if (data_pend) begin
        check("drive_data", data_bus_out, pend_data);
        data_pend = 0;
      end
      if (post_rel) begin
        check("release_grant", source_grant, 0);
        check("release_data", data_bus_out, 0);
        check("release_dir", data_bus_direction, 0);
        post_rel = 0;
      end
      if (ra && !in_txn) begin
        in_txn = 1; done = 0; stall_cnt = 0;
      end
      if (in_txn) begin
        if (!ra) begin
          if (!done) begin
            if (sb_q.size() == 0) check("sb_empty_abort", 1, 0);
            else begin
              e = sb_q.pop_front();
              check("abort_kind", 1, e.abort);
              check("abort_stall", stall_cnt, e.stall);
            end
          end
          in_txn = 0;
          post_rel = 1;
        end else if (!done) begin
          if (!access_ready) begin
            stall_cnt++;
            check("stall_no_timeout", bus_timeout, 0);
          end else if (sb_q.size() == 0) begin
            check("sb_empty_done", 1, 0);
            done = 1;
          end else begin
            e = sb_q.pop_front();
            check("done_kind", 0, e.abort);
            check("stall_cycles", stall_cnt, e.stall);
            check("grant", source_grant, e.grant);
            check("direction", data_bus_direction, e.dir);
            check("timeout_pulse", bus_timeout, e.tmo);
            pend_data = e.data;
            cur_grant = e.grant;
            data_pend = 1;
            done = 1;
          end
        end else begin
          check("ready_hold", access_ready, 1);
          check("timeout_once", bus_timeout, 0);
          check("grant_locked", source_grant, cur_grant);
        end
      end
    end
  end

  task automatic set_ws(input int idx, input int val);
    wait_states[idx*WW +: WW] = WW'(val);
  endtask

  initial begin
    int r;
    #1;
    check("rst_data", data_bus_out, 0);
    check("rst_dir", data_bus_direction, 0);
    check("rst_grant", source_grant, 0);
    check("rst_ready", access_ready, 1);
    check("rst_timeout", bus_timeout, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Source 1 with three wait states.
    wait_states = '0;
    set_ws(1, 3);
    source_data = {8'h11, 8'h22, 8'h5A, 8'h33};
    run_txn(4'b1101, 1'b0, 0, -1, 2, 1, 1'b0);
    // Source 0 via I/O read, selects scrambled mid-cycle.
    run_txn(4'b1100, 1'b0, 0, -1, 3, 1, 1'b1);
    // External bus.
    data_bus_ext = 8'hC3;
    run_txn(4'b1111, 1'b1, 0, -1, 2, 1, 1'b0);
    // Nothing selected, no external: drives zero.
    run_txn(4'b1111, 1'b0, 0, -1, 2, 1, 1'b0);
    // Source 2 never ready: forced completion.
    run_txn(4'b1011, 1'b0, NEVER, -1, 2, 1, 1'b0);
    // Ready and wait expiry coincide with the timeout: normal completion wins.
    set_ws(2, TMO);
    run_txn(4'b1011, 1'b0, TMO, -1, 2, 1, 1'b0);
    // Abort during WAIT.
    set_ws(2, 5);
    run_txn(4'b1011, 1'b0, 0, 3, 2, 1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      logic [SRC-1:0] sel;
      for (int i = 0; i < SRC; i++) set_ws(i, $urandom_range(6, 0));
      source_data = SRC*DW'({$urandom, $urandom});
      data_bus_ext = DW'($urandom);
      sel = ($urandom_range(3, 0) == 0) ? '1 : SRC'($urandom);
      case ($urandom_range(2, 0))
        0: r = 0;
        1: r = $urandom_range(10, 0);
        default: r = NEVER;
      endcase
      run_txn(sel, 1'($urandom), r, ($urandom_range(4, 0) == 0) ? $urandom_range(5, 1) : -1,
              $urandom_range(4, 2), $urandom_range(3, 1), 1'($urandom));
    end

    repeat (4) @(posedge clock);
    #1;
    check("sb_drained", sb_q.size(), 0);

    // Asynchronous reset in the middle of WAIT.
    mon_en = 1'b0;
    wait_states = '0;
    set_ws(2, 6);
    source_data = {8'h44, 8'h99, 8'h55, 8'h66};
    source_select_n = 4'b1011;
    memory_read_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("pre_reset_grant", source_grant, 4'b0100);
    check("pre_reset_ready", access_ready, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_grant", source_grant, 0);
    check("async_rst_data", data_bus_out, 0);
    check("async_rst_dir", data_bus_direction, 0);
    check("async_rst_ready", access_ready, 1);
    check("async_rst_timeout", bus_timeout, 0);
    memory_read_n = 1'b1;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    set_ws(2, 2);
    run_txn(4'b1011, 1'b0, 0, -1, 2, 2, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("sb_final", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
